// File: rtl/fifo_pkg.sv
// Shared async-FIFO types and helpers.
// Pointer conversion and bit counting used by the pointer-crossing blocks.
package fifo_pkg;

  localparam int ADDRSIZE_DEF = 4;

  typedef enum logic {
    AF_CLR,
    AF_SET
  } af_state_t;

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic int popcount(input logic [31:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Generic multi-flop synchronizer.
// Plain flop chain; nothing may sit between stages.
module sync_ff_chain #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stg [STAGES];

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stg[i] <= '0;
      end
    end else begin
      stg[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stg[i] <= stg[i-1];
      end
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/rptr_sync_wlevel.sv
// Write-domain end of the read-pointer crossing: sync, Gray->binary,
// fill level, free space, hysteretic almost-full and CDC error flags.
module rptr_sync_wlevel
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE    = ADDRSIZE_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int AF_HI       = 12,
  parameter int AF_LO       = 8
) (
  input  logic              wclk,
  input  logic              wrst_n,
  input  logic [ADDRSIZE:0] rptr,
  input  logic [ADDRSIZE:0] wbin,
  input  logic              wclr_err,
  output logic [ADDRSIZE:0] wq2_rptr,
  output logic [ADDRSIZE:0] wq2_rbin,
  output logic [ADDRSIZE:0] wlevel,
  output logic [ADDRSIZE:0] wfree,
  output logic              walmost_full,
  output logic              werr_gray,
  output logic              werr_level
);

  localparam int PW    = ADDRSIZE + 1;
  localparam int DEPTH = 2 ** ADDRSIZE;

  logic [PW-1:0] prev_rptr;
  logic [PW-1:0] level_nxt;
  logic          gray_bad;
  logic          level_bad;
  af_state_t     af_state;

  sync_ff_chain #(
    .WIDTH (PW),
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .wclk  (wclk),
    .wrst_n(wrst_n),
    .d     (rptr),
    .q     (wq2_rptr)
  );

  // Modular subtract absorbs pointer wrap.
  assign level_nxt = wbin - wq2_rbin;
  assign level_bad = level_nxt > PW'(DEPTH);
  assign gray_bad  = popcount(32'(prev_rptr ^ wq2_rptr)) > 1;

  assign wfree        = PW'(DEPTH) - wlevel;
  assign walmost_full = (af_state == AF_SET);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wq2_rbin   <= '0;
      prev_rptr  <= '0;
      wlevel     <= '0;
      af_state   <= AF_CLR;
      werr_gray  <= 1'b0;
      werr_level <= 1'b0;
    end else begin
      wq2_rbin  <= PW'(gray2bin(32'(wq2_rptr)));
      prev_rptr <= wq2_rptr;
      wlevel    <= level_nxt;
      unique case (af_state)
        AF_CLR:
          if (level_nxt >= PW'(AF_HI)) af_state <= AF_SET;
        AF_SET:
          if (level_nxt <= PW'(AF_LO)) af_state <= AF_CLR;
        default: af_state <= AF_CLR;
      endcase
      // A fresh error outranks a simultaneous clear.
      werr_gray  <= gray_bad  | (werr_gray  & ~wclr_err);
      werr_level <= level_bad | (werr_level & ~wclr_err);
    end
  end

endmodule

// File: tb/tb_rptr_sync_wlevel.sv
// Directed bench for rptr_sync_wlevel (ADDRSIZE=4, 2 sync stages).
// Inputs change 1 ns after the rising edge; outputs are checked there too.
module tb_rptr_sync_wlevel;

  logic       wclk;
  logic       wrst_n;
  logic [4:0] rptr;
  logic [4:0] wbin;
  logic       wclr_err;
  logic [4:0] wq2_rptr;
  logic [4:0] wq2_rbin;
  logic [4:0] wlevel;
  logic [4:0] wfree;
  logic       walmost_full;
  logic       werr_gray;
  logic       werr_level;

  int checks;
  int failures;

  rptr_sync_wlevel #(
    .ADDRSIZE   (4),
    .SYNC_STAGES(2),
    .AF_HI      (12),
    .AF_LO      (8)
  ) dut (
    .wclk        (wclk),
    .wrst_n      (wrst_n),
    .rptr        (rptr),
    .wbin        (wbin),
    .wclr_err    (wclr_err),
    .wq2_rptr    (wq2_rptr),
    .wq2_rbin    (wq2_rbin),
    .wlevel      (wlevel),
    .wfree       (wfree),
    .walmost_full(walmost_full),
    .werr_gray   (werr_gray),
    .werr_level  (werr_level)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge wclk);
    #3;
    wrst_n = 1'b0;
    rptr = '0;
    wbin = '0;
    wclr_err = 1'b0;
    step(2);
    wrst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    wrst_n = 1'b0;
    rptr = '0;
    wbin = '0;
    wclr_err = 1'b0;
    step(2);
    chk("rst_level", 32'(wlevel), 0);
    chk("rst_free", 32'(wfree), 16);
    chk("rst_af", 32'(walmost_full), 0);
    chk("rst_egray", 32'(werr_gray), 0);
    chk("rst_elevel", 32'(werr_level), 0);
    wrst_n = 1'b1;
    step(1);

    // Latency: rptr=Gray(2), wbin=5
    rptr = 5'h03;
    wbin = 5'd5;
    step(1);
    chk("lat_e1_level", 32'(wlevel), 5);
    step(1);
    chk("lat_e2_q2", 32'(wq2_rptr), 3);
    chk("lat_e2_rbin", 32'(wq2_rbin), 0);
    step(1);
    chk("lat_e3_rbin", 32'(wq2_rbin), 2);
    chk("lat_e3_level", 32'(wlevel), 5);
    step(1);
    chk("lat_e4_level", 32'(wlevel), 3);
    chk("lat_e4_free", 32'(wfree), 13);

    // Ramp to almost-full, then drain via Gray steps
    do_reset();
    for (int k = 0; k <= 12; k++) begin
      wbin = 5'(k);
      step(1);
      chk("ramp_level", 32'(wlevel), 32'(k));
      chk("ramp_af", 32'(walmost_full), (k >= 12) ? 1 : 0);
    end
    rptr = 5'h01;
    step(4);
    chk("drain11_level", 32'(wlevel), 11);
    chk("drain11_af", 32'(walmost_full), 1);
    rptr = 5'h03;
    step(4);
    chk("drain10_af", 32'(walmost_full), 1);
    rptr = 5'h02;
    step(4);
    chk("drain9_level", 32'(wlevel), 9);
    chk("drain9_af", 32'(walmost_full), 1);
    rptr = 5'h06;
    step(4);
    chk("drain8_level", 32'(wlevel), 8);
    chk("drain8_af", 32'(walmost_full), 0);
    wbin = 5'd13;
    step(1);
    chk("hyst9_af", 32'(walmost_full), 0);
    wbin = 5'd15;
    step(1);
    chk("hyst11_level", 32'(wlevel), 11);
    chk("hyst11_af", 32'(walmost_full), 0);
    chk("drain_egray", 32'(werr_gray), 0);

    // Wrap: wbin=2, rptr=Gray(30)
    do_reset();
    rptr = 5'h11;
    wbin = 5'd2;
    step(4);
    chk("wrap_rbin", 32'(wq2_rbin), 30);
    chk("wrap_level", 32'(wlevel), 4);
    chk("wrap_free", 32'(wfree), 12);
    chk("wrap_elevel", 32'(werr_level), 0);

    // Gray integrity error, sticky, clear, clear vs new error
    do_reset();
    rptr = 5'h07;
    step(2);
    chk("gerr_e2", 32'(werr_gray), 0);
    step(1);
    chk("gerr_e3", 32'(werr_gray), 1);
    step(3);
    chk("gerr_sticky", 32'(werr_gray), 1);
    wclr_err = 1'b1;
    step(1);
    wclr_err = 1'b0;
    chk("gerr_clear", 32'(werr_gray), 0);
    rptr = 5'h00;
    step(2);
    wclr_err = 1'b1;
    step(1);
    wclr_err = 1'b0;
    chk("gerr_clr_race", 32'(werr_gray), 1);
    wclr_err = 1'b1;
    step(1);
    wclr_err = 1'b0;
    chk("gerr_clear2", 32'(werr_gray), 0);

    // Level boundary and overflow error
    do_reset();
    wbin = 5'd16;
    step(1);
    chk("full_level", 32'(wlevel), 16);
    chk("full_free", 32'(wfree), 0);
    chk("full_elevel", 32'(werr_level), 0);
    chk("full_af", 32'(walmost_full), 1);
    wbin = 5'd17;
    step(1);
    chk("ovf_level", 32'(wlevel), 17);
    chk("ovf_elevel", 32'(werr_level), 1);
    wclr_err = 1'b1;
    step(1);
    chk("ovf_clr_race", 32'(werr_level), 1);
    wbin = 5'd3;
    step(1);
    wclr_err = 1'b0;
    chk("ovf_clear", 32'(werr_level), 0);

    // Async reset mid-operation
    do_reset();
    wbin = 5'd14;
    rptr = 5'h00;
    step(1);
    chk("pre_rst_level", 32'(wlevel), 14);
    chk("pre_rst_af", 32'(walmost_full), 1);
    #2;
    wrst_n = 1'b0;
    #1;
    chk("arst_level", 32'(wlevel), 0);
    chk("arst_free", 32'(wfree), 16);
    chk("arst_af", 32'(walmost_full), 0);
    @(negedge wclk);
    wrst_n = 1'b1;
    step(4);
    chk("post_rst_level", 32'(wlevel), 14);
    chk("post_rst_af", 32'(walmost_full), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
